alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each accepted operation walks IDLE -> EXEC -> RESP and returns to IDLE
// on the response handshake.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; left undefined, requester 0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              busy
);

    localparam int unsigned OP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_gnt_id;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_carry;
    logic              r_rsp_overflow;
`ifdef ALU_ARB_RR_EN
    logic              r_last_gnt;
`endif

    logic              w_gnt_id;
    logic              w_accept;
    logic              w_rsp_hs;

    // Arbitration: choose a requester and decide whether it is accepted now
    always_comb begin
        w_gnt_id = 1'b0;
`ifdef ALU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last_gnt;
        end else begin
            w_gnt_id = ~req0_valid;
        end
`else
        w_gnt_id = ~req0_valid;
`endif
        w_accept = rst_n && (r_state == ST_IDLE) && (req0_valid || req1_valid);
        w_rsp_hs = r_gnt_id ? rsp1_ready : rsp0_ready;
    end

    // Operation sequencing, operand latching and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_gnt_id       <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_rsp0_valid   <= 1'b0;
            r_rsp1_valid   <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
`ifdef ALU_ARB_RR_EN
            r_last_gnt     <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt_id <= w_gnt_id;
                        r_alu_a  <= w_gnt_id ? req1_a  : req0_a;
                        r_alu_b  <= w_gnt_id ? req1_b  : req0_b;
                        r_alu_op <= w_gnt_id ? req1_op : req0_op;
`ifdef ALU_ARB_RR_EN
                        r_last_gnt <= w_gnt_id;
`endif
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result   <= alu_result;
                    r_rsp_zero     <= alu_zero;
                    r_rsp_carry    <= alu_carry;
                    r_rsp_overflow <= alu_overflow;
                    r_rsp0_valid   <= ~r_gnt_id;
                    r_rsp1_valid   <= r_gnt_id;
                    r_state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready   = w_accept && !w_gnt_id;
    assign req1_ready   = w_accept && w_gnt_id;
    assign rsp0_valid   = r_rsp0_valid;
    assign rsp1_valid   = r_rsp1_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_overflow = r_rsp_overflow;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;

    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]        req0_op, req1_op;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero, rsp_carry, rsp_overflow;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero, alu_carry, alu_overflow;
    logic              busy;

    int n_checks;
    int n_fail;

    alu_arbiter #(.DATA_W(DATA_W)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .req1_ready   (req1_ready),
        .rsp0_valid   (rsp0_valid),
        .rsp1_valid   (rsp1_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_ready   (rsp1_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: and/or/add/sub/slt/nor/eq, anything else adds
    logic [DATA_W:0] w_wide;
    always_comb begin
        w_wide       = '0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0110: begin
                w_wide       = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result   = w_wide[DATA_W-1:0];
                alu_carry    = w_wide[DATA_W];
                alu_overflow = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                               (alu_result[DATA_W-1] != alu_a[DATA_W-1]);
            end
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_a | alu_b);
            4'b1111: alu_result = (alu_a == alu_b) ? 32'd1 : 32'd0;
            default: begin
                w_wide       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = w_wide[DATA_W-1:0];
                alu_carry    = w_wide[DATA_W];
                alu_overflow = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                               (alu_result[DATA_W-1] != alu_a[DATA_W-1]);
            end
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input bit id, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        if (!id) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // One isolated operation: accept at N, EXEC at N+1, response at N+2
    task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] er, input logic [2:0] ef);
        @(negedge clk);
        set_req(id, 1'b1, a, b, op);
        #1;
        chk("acc_ready", 32'(id ? req1_ready : req0_ready), 32'd1);
        chk("acc_other", 32'(id ? req0_ready : req1_ready), 32'd0);
        @(negedge clk);
        set_req(id, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_op", 32'(alu_op), 32'(op));
        chk("exec_noval", 32'(rsp0_valid | rsp1_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("rsp_valid", 32'(id ? rsp1_valid : rsp0_valid), 32'd1);
        chk("rsp_other", 32'(id ? rsp0_valid : rsp1_valid), 32'd0);
        chk("rsp_result", rsp_result, er);
        chk("rsp_flags", 32'({rsp_zero, rsp_carry, rsp_overflow}), 32'(ef));
        if (!id) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        chk("rsp_done", 32'(rsp0_valid | rsp1_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   found;
        logic gid;
        logic exp_id;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state with a request present
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b1;

        // Directed ALU vectors
        do_op(1'b0, 32'd5,          32'd3,          4'b0010, 32'd8,          3'b000);
        do_op(1'b1, 32'h7FFF_FFFF,  32'd1,          4'b0010, 32'h8000_0000,  3'b001);
        do_op(1'b1, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          3'b110);
        do_op(1'b0, 32'd3,          32'd5,          4'b0110, 32'hFFFF_FFFE,  3'b000);
        do_op(1'b0, 32'hFFFF_FFFF,  32'd1,          4'b0111, 32'd1,          3'b000);
        do_op(1'b1, 32'hA5,         32'hA5,         4'b1111, 32'd1,          3'b000);
        do_op(1'b0, 32'd2,          32'd3,          4'b0011, 32'd5,          3'b000);

        // ALU drive holds the last latched operands while idle
        @(negedge clk);
        #1;
        chk("hold_alu_a", alu_a, 32'd2);
        chk("hold_alu_op", 32'(alu_op), 32'd3);

        // Response back-pressure: result held, no new grant, foreign ready ignored
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'd10, 32'd20, 4'b0010);
        #1;
        chk("bp_acc", 32'(req0_ready), 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        chk("bp_rsp", 32'(rsp0_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_req(1'b1, 1'b1, 32'd1, 32'd1, 4'b0010);
            rsp1_ready = 1'b1;
            #1;
            chk("bp_valid", 32'(rsp0_valid), 32'd1);
            chk("bp_result", rsp_result, 32'd30);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_nogrant", 32'(req1_ready), 32'd0);
        end
        @(negedge clk);
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        #1;
        chk("bp_still", 32'(rsp0_valid), 32'd1);
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        chk("bp_next_gnt", 32'(req1_ready), 32'd1);
        chk("bp_rsp_gone", 32'(rsp0_valid), 32'd0);
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        chk("bp_rsp1", 32'(rsp1_valid), 32'd1);
        chk("bp_rsp1_res", rsp_result, 32'd2);
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset during EXEC abandons the operation; held request re-accepted
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'd4, 32'd4, 4'b0010);
        #1;
        chk("mr_acc", 32'(req0_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_exec", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rsp0", 32'(rsp0_valid), 32'd0);
        chk("mr_alu_op", 32'(alu_op), 32'd0);
        chk("mr_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_reacc", 32'(req0_ready), 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        chk("mr_rsp", 32'(rsp0_valid), 32'd1);
        chk("mr_result", rsp_result, 32'd8);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;

        // Contention: both requesting continuously, responses taken at once
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1'b0, 1'b1, 32'd1,  32'd1,  4'b0010);
        set_req(1'b1, 1'b1, 32'd10, 32'd20, 4'b0010);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            gid   = 1'b0;
            for (int k = 0; k < 6 && !found; k++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    found = 1'b1;
                    gid   = req1_ready;
                end
                @(negedge clk);
            end
`ifdef ALU_ARB_RR_EN
            exp_id = g[0];
`else
            exp_id = 1'b0;
`endif
            if (!found) chk("gnt_timeout", 32'd0, 32'd1);
            else        chk("gnt_id", 32'(gid), 32'(exp_id));
        end
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
